// File: rtl/ldm_scan_ctrl.sv
// LED dot-matrix row-scan controller: fetches a row from the frame buffer,
// shifts it out MSB first, latches the row address, then enables the panel for a dwell time.
module ldm_scan_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int CLK_HALF  = 1,
  parameter int LAT_CYC   = 1,
  parameter int DWELL_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COLS-1:0]   rd_data,
  output logic              LDM_CLK,
  output logic              LDM_DATA,
  output logic              LDM_LAT,
  output logic              LDM_ADDR_EN,
  output logic [ADDR_W-1:0] LDM_ADDR,
  output logic              LDM_OE,
  output logic              frame_done,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int MAX_A = (CLK_HALF > LAT_CYC) ? CLK_HALF : LAT_CYC;
  localparam int MAX_C = (MAX_A > DWELL_CYC) ? MAX_A : DWELL_CYC;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int BW    = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CW-1:0]     HALF_LAST  = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0]     LAT_LAST   = CW'(LAT_CYC - 1);
  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [BW-1:0]     BIT_LAST   = BW'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_LATCH = 3'd4,
    S_DWELL = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [COLS-1:0]     sreg_q, sreg_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                ldm_clk_q, ldm_clk_d;
  logic                ldm_data_q, ldm_data_d;
  logic                ldm_lat_q, ldm_lat_d;
  logic                ldm_addr_en_q, ldm_addr_en_d;
  logic [ADDR_W-1:0]   ldm_addr_q, ldm_addr_d;
  logic                ldm_oe_q, ldm_oe_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  // Control path: next state and counters. cnt is shared by the half-period,
  // latch and dwell timers since only one of them runs at a time.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sreg_d     = sreg_q;
    ldm_clk_d  = ldm_clk_q;
    ldm_data_d = ldm_data_q;
    ldm_addr_d = ldm_addr_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d    = S_SHIFT;
        sreg_d     = rd_data;
        bit_d      = BIT_LAST;
        cnt_d      = '0;
        ldm_clk_d  = 1'b0;
        ldm_data_d = rd_data[COLS-1];
      end
      S_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!ldm_clk_q) begin
            ldm_clk_d = 1'b1;
          end else if (bit_q == '0) begin
            state_d    = S_LATCH;
            ldm_clk_d  = 1'b0;
            ldm_data_d = 1'b0;
            ldm_addr_d = row_q;
          end else begin
            // Data only advances on the falling edge of the panel clock.
            bit_d      = bit_q - BW'(1);
            sreg_d     = sreg_q << 1;
            ldm_clk_d  = 1'b0;
            ldm_data_d = sreg_d[COLS-1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + ADDR_W'(1);
          state_d = en ? S_FETCH : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output strobes are decoded from the next state so every pin is a flop.
  always_comb begin
    rd_en_d       = (state_d == S_FETCH);
    rd_addr_d     = (state_d == S_FETCH) ? row_d : rd_addr_q;
    ldm_lat_d     = (state_d == S_LATCH);
    ldm_addr_en_d = (state_d == S_LATCH);
    ldm_oe_d      = (state_d == S_DWELL);
    busy_d        = (state_d != S_IDLE);
    frame_done_d  = (state_d == S_DWELL) && (cnt_d == DWELL_LAST) && (row_q == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      cnt_q         <= '0;
      bit_q         <= '0;
      sreg_q        <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      ldm_clk_q     <= 1'b0;
      ldm_data_q    <= 1'b0;
      ldm_lat_q     <= 1'b0;
      ldm_addr_en_q <= 1'b0;
      ldm_addr_q    <= '0;
      ldm_oe_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      sreg_q        <= sreg_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      ldm_clk_q     <= ldm_clk_d;
      ldm_data_q    <= ldm_data_d;
      ldm_lat_q     <= ldm_lat_d;
      ldm_addr_en_q <= ldm_addr_en_d;
      ldm_addr_q    <= ldm_addr_d;
      ldm_oe_q      <= ldm_oe_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign LDM_CLK     = ldm_clk_q;
  assign LDM_DATA    = ldm_data_q;
  assign LDM_LAT     = ldm_lat_q;
  assign LDM_ADDR_EN = ldm_addr_en_q;
  assign LDM_ADDR    = ldm_addr_q;
  assign LDM_OE      = ldm_oe_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Bench for ldm_scan_ctrl: two instances (fast 4x4 and slow-clock 4x2), a pin monitor that
// rebuilds one record per scanned row and checks it against a queue of expected rows.
module tb_ldm_scan_ctrl;

  logic clk, rst, en0, en1;

  logic       rd_en0, lclk0, ldat0, llat0, laen0, loe0, fd0, busy0;
  logic [1:0] rd_addr0, laddr0;
  logic [3:0] rd_data0;
  logic [2:0] st0;

  logic       rd_en1, lclk1, ldat1, llat1, laen1, loe1, fd1, busy1;
  logic [1:0] rd_addr1, laddr1;
  logic [1:0] rd_data1;
  logic [2:0] st1;

  ldm_scan_ctrl #(.ADDR_W(2), .ROWS(4), .COLS(4), .CLK_HALF(1), .LAT_CYC(1), .DWELL_CYC(3)) u_dut0 (
    .clk(clk), .rst(rst), .en(en0), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .LDM_CLK(lclk0), .LDM_DATA(ldat0), .LDM_LAT(llat0), .LDM_ADDR_EN(laen0), .LDM_ADDR(laddr0),
    .LDM_OE(loe0), .frame_done(fd0), .busy(busy0), .dbg_state(st0)
  );

  ldm_scan_ctrl #(.ADDR_W(2), .ROWS(4), .COLS(2), .CLK_HALF(3), .LAT_CYC(1), .DWELL_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .LDM_CLK(lclk1), .LDM_DATA(ldat1), .LDM_LAT(llat1), .LDM_ADDR_EN(laen1), .LDM_ADDR(laddr1),
    .LDM_OE(loe1), .frame_done(fd1), .busy(busy1), .dbg_state(st1)
  );

  // ---------------- clock / reset ----------------
  int cyc_cnt = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  // ---------------- frame buffers (1-cycle read latency) ----------------
  logic [3:0] fb0 [4] = '{4'b1010, 4'b0111, 4'b1001, 4'b0100};
  logic [1:0] fb1 [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic ren0_d = 1'b0, ren1_d = 1'b0;

  // Data appears after the read strobe, holds for one cycle, then becomes junk.
  always @(negedge clk) begin
    if (rd_en0) rd_data0 = fb0[rd_addr0];
    else if (!ren0_d) rd_data0 = 4'($urandom);
    ren0_d = rd_en0;
    if (rd_en1) rd_data1 = fb1[rd_addr1];
    else if (!ren1_d) rd_data1 = 2'($urandom);
    ren1_d = rd_en1;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_fail = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  function automatic logic [31:0] row_word(input logic [1:0] ra, input logic [1:0] la,
                                           input logic [3:0] bits, input logic [3:0] nb,
                                           input logic [3:0] lc, input logic [3:0] oc,
                                           input logic [1:0] fd, input logic [1:0] er,
                                           input logic [7:0] per);
    return {ra, la, bits, nb, lc, oc, fd, er, per};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         m_cyc  [2];
  logic [1:0] m_ra   [2];
  logic [1:0] m_la   [2];
  logic [3:0] m_bits [2];
  logic [3:0] m_nb   [2];
  logic [3:0] m_lc   [2];
  logic [3:0] m_oc   [2];
  logic [1:0] m_fd   [2];
  logic [1:0] m_er   [2];
  logic       m_pclk [2];
  logic       m_pdat [2];
  logic       m_poe  [2];
  logic       m_plat [2];
  logic [1:0] m_pla  [2];

  task automatic mon_step(input int i, input logic ren, input logic [1:0] ra, input logic lclk,
                          input logic ldat, input logic llat, input logic laen,
                          input logic [1:0] la, input logic oe, input logic fd);
    logic [31:0] got;
    logic [31:0] exp;
    if (m_poe[i] && !oe) begin
      got = row_word(m_ra[i], m_la[i], m_bits[i], m_nb[i], m_lc[i], m_oc[i], m_fd[i], m_er[i],
                     8'(m_cyc[i]));
      if (i == 0 && exp_q0.size() > 0) begin
        exp = exp_q0.pop_front();
        check($sformatf("row_inst0_addr%0d", m_ra[i]), got, exp);
      end else if (i == 1 && exp_q1.size() > 0) begin
        exp = exp_q1.pop_front();
        check($sformatf("row_inst1_addr%0d", m_ra[i]), got, exp);
      end else begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_row inst%0d: got %h expected none", i, got);
      end
    end
    if (ren) begin
      m_cyc[i]  = 1;
      m_ra[i]   = ra;
      m_bits[i] = '0;
      m_nb[i]   = '0;
      m_lc[i]   = '0;
      m_oc[i]   = '0;
      m_fd[i]   = '0;
      m_er[i]   = '0;
    end else begin
      m_cyc[i] = m_cyc[i] + 1;
    end
    if (lclk && !m_pclk[i]) begin
      m_bits[i] = {m_bits[i][2:0], ldat};
      m_nb[i]   = m_nb[i] + 4'd1;
    end
    if (lclk && m_pclk[i] && (ldat != m_pdat[i])) m_er[i][0] = 1'b1;
    if (llat != laen) m_er[i][1] = 1'b1;
    if (llat) begin
      m_lc[i] = m_lc[i] + 4'd1;
      m_la[i] = la;
    end
    if ((la != m_pla[i]) && !(llat && !m_plat[i])) m_er[i][1] = 1'b1;
    if (oe) m_oc[i] = m_oc[i] + 4'd1;
    if (oe && (lclk || llat)) m_er[i][1] = 1'b1;
    if (fd) begin
      m_fd[i] = m_fd[i] + 2'd1;
      if (!oe) m_er[i][1] = 1'b1;
    end
    m_pclk[i] = lclk;
    m_pdat[i] = ldat;
    m_poe[i]  = oe;
    m_plat[i] = llat;
    m_pla[i]  = la;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_pclk[i] = 1'b0;
        m_pdat[i] = 1'b0;
        m_poe[i]  = 1'b0;
        m_plat[i] = 1'b0;
        m_pla[i]  = 2'd0;
        m_cyc[i]  = 0;
      end
    end else begin
      mon_step(0, rd_en0, rd_addr0, lclk0, ldat0, llat0, laen0, laddr0, loe0, fd0);
      mon_step(1, rd_en1, rd_addr1, lclk1, ldat1, llat1, laen1, laddr1, loe1, fd1);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_row0(input int r);
    exp_q0.push_back(row_word(2'(r), 2'(r), fb0[r], 4'd4, 4'd1, 4'd3,
                              (r == 3) ? 2'd1 : 2'd0, 2'd0, 8'd14));
  endtask

  task automatic push_row1(input int r);
    exp_q1.push_back(row_word(2'(r), 2'(r), {2'b00, fb1[r]}, 4'd2, 4'd1, 4'd3,
                              2'd0, 2'd0, 8'd18));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t;
    int t_a;
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    tick(3);
    check("reset_out0", {rd_en0, rd_addr0, lclk0, ldat0, llat0, laen0, laddr0, loe0, fd0, busy0, st0}, 32'd0);
    check("reset_out1", {rd_en1, rd_addr1, lclk1, ldat1, llat1, laen1, laddr1, loe1, fd1, busy1, st1}, 32'd0);

    // Reset in the middle of the first row's shift.
    rst = 1'b0;
    en0 = 1'b1;
    t = 0;
    while (!lclk0 && t < 20) begin tick(1); t++; end
    check("shift_reached", 32'(lclk0), 32'd1);
    rst = 1'b1;
    tick(1);
    check("midrst_out", {rd_en0, rd_addr0, lclk0, ldat0, llat0, laen0, laddr0, loe0, fd0, busy0, st0}, 32'd0);

    // Two full frames plus rows 0 and 1 of the third.
    for (int k = 0; k < 10; k++) push_row0(k % 4);
    rst = 1'b0;
    tick(1);
    check("restart_fetch", {rd_en0, rd_addr0}, {29'd0, 1'b1, 2'd0});

    t = 0;
    while (!fd0 && t < 200) begin tick(1); t++; end
    check("fd_seen_a", 32'(fd0), 32'd1);
    t_a = cyc_cnt;
    tick(1);
    t = 0;
    while (!fd0 && t < 200) begin tick(1); t++; end
    check("fd_seen_b", 32'(fd0), 32'd1);
    check("fd_period", 32'(cyc_cnt - t_a), 32'd56);

    // Stop during row 1's shift; the row finishes and the controller parks.
    t = 0;
    while (!(rd_en0 && rd_addr0 == 2'd1) && t < 60) begin tick(1); t++; end
    check("row1_fetch", {rd_en0, rd_addr0}, {29'd0, 1'b1, 2'd1});
    t = 0;
    while (!lclk0 && t < 20) begin tick(1); t++; end
    check("row1_shift", 32'(lclk0), 32'd1);
    en0 = 1'b0;
    t = 0;
    while (busy0 && t < 60) begin tick(1); t++; end
    check("stop_idle", {busy0, st0}, 32'd0);
    tick(4);
    check("stay_idle", {rd_en0, busy0, loe0}, 32'd0);

    // Resume picks up at row 2.
    push_row0(2);
    push_row0(3);
    en0 = 1'b1;
    tick(1);
    check("resume_fetch", {rd_en0, rd_addr0}, {29'd0, 1'b1, 2'd2});
    t = 0;
    while (!fd0 && t < 60) begin tick(1); t++; end
    check("fd_seen_c", 32'(fd0), 32'd1);
    en0 = 1'b0;
    t = 0;
    while (busy0 && t < 20) begin tick(1); t++; end
    check("end_idle", 32'(busy0), 32'd0);

    // Slow panel clock instance: two rows then stop.
    push_row1(0);
    push_row1(1);
    en1 = 1'b1;
    tick(1);
    check("slow_fetch", {rd_en1, rd_addr1}, {29'd0, 1'b1, 2'd0});
    t = 0;
    while (!(rd_en1 && rd_addr1 == 2'd1) && t < 40) begin tick(1); t++; end
    check("slow_row1_fetch", {rd_en1, rd_addr1}, {29'd0, 1'b1, 2'd1});
    en1 = 1'b0;
    t = 0;
    while (busy1 && t < 40) begin tick(1); t++; end
    check("slow_idle", 32'(busy1), 32'd0);

    tick(3);
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
